// File: rtl/cpu_pkg.sv
// Shared definitions for the single-issue MIPS CPU: fetch FSM states,
// fetch constants and primary opcode values used when decoding words.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline boundary register. Holds by default, loads a fetched
// instruction on i_load, and is forced to a bubble (all zero) on i_bubble
// or reset. A bubble wins over a load.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_instr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc4,
  output logic [31:0]       o_instr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc4;
  logic [31:0]       r_instr;

  // Capture, squash or hold the IF/ID contents
  always_ff @(posedge i_clk) begin
    if (i_rst || i_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_instr <= INSTR_NOP;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + ADDR_W'(PC_STEP);
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and the IDLE/RUN/FAULT control
// FSM, addresses instruction memory with the PC and feeds the IF/ID register.
//
// Handshake note: there is no valid/ready pair here. stall_i is the
// back-pressure: while it is high (and no redirect is present) the PC and
// IF/ID hold, so decode sees a stable ifid_* until stall_i drops.
// ifid_valid_o marks a real instruction; a bubble is all zero.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  output logic              ifid_valid_o,
  output logic [ADDR_W-1:0] ifid_pc_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic [31:0]       ifid_instr_o,
  output logic [31:0]       fetch_cnt_o,
  output logic              running_o,
  output logic              fault_o
);

  // First byte address past the end of instruction memory
  localparam logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(IMEM_DEPTH * PC_STEP);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_fetch_cnt;
  logic              r_running;
  logic              r_fault;

  logic w_run;
  logic w_redir_ok;
  logic w_redir_bad;
  logic w_stall;
  logic w_oor;
  logic w_normal;
  logic w_load;
  logic w_bubble;
  logic [ADDR_W-1:0] w_pc_next;

  // Decode the RUN-state priority chain: redirect, bad redirect, stall,
  // out-of-range, normal fetch. Outside RUN none of these fire.
  always_comb begin
    w_run       = (r_state == RUN);
    w_redir_ok  = w_run && redirect_i && (redirect_pc_i[1:0] == 2'b00);
    w_redir_bad = w_run && redirect_i && (redirect_pc_i[1:0] != 2'b00);
    w_stall     = w_run && !redirect_i && stall_i;
    w_oor       = w_run && !redirect_i && !stall_i && (r_pc >= IMEM_BYTES);
    w_normal    = w_run && !redirect_i && !stall_i && !w_oor;
    w_load      = w_normal && !flush_i;
    w_bubble    = w_redir_ok || w_redir_bad || w_oor || ((w_stall || w_normal) && flush_i);
    w_pc_next   = r_pc + ADDR_W'(PC_STEP);
  end

  // Control FSM with PC, capture counter and registered status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
      r_running   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_redir_ok) begin
            r_pc <= redirect_pc_i;
          end else if (w_redir_bad || w_oor) begin
            r_state   <= FAULT;
            r_running <= 1'b0;
            r_fault   <= 1'b1;
          end else if (w_normal) begin
            r_pc <= w_pc_next;
            if (w_load) r_fetch_cnt <= r_fetch_cnt + 32'd1;
          end
        end
        FAULT: begin
          // Frozen until reset
        end
        default: begin
          r_state   <= FAULT;
          r_running <= 1'b0;
          r_fault   <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_load  (w_load),
    .i_bubble(w_bubble),
    .i_pc    (r_pc),
    .i_instr (imem_instr_i),
    .o_valid (ifid_valid_o),
    .o_pc    (ifid_pc_o),
    .o_pc4   (ifid_pc4_o),
    .o_instr (ifid_instr_o)
  );

  assign imem_addr_o = r_pc;
  assign fetch_cnt_o = r_fetch_cnt;
  assign running_o   = r_running;
  assign fault_o     = r_fault;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the single-issue MIPS CPU.
- Owns the program counter and gates execution on start_i.
- Drives the instruction-memory read address.
- Registers the fetched instruction into the IF/ID boundary consumed by decode/register-file read.
- Handles stall, flush, branch/jump redirect and out-of-range fetch faults.

Parameters:
- ADDR_W, 32, PC and address width.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; valid byte addresses are 0 to IMEM_DEPTH*4-4.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  run enable; sampled only in IDLE.
- stall_i  in  1  hold PC and IF/ID contents.
- flush_i  in  1  replace the next IF/ID capture with a bubble.
- redirect_i  in  1  taken branch/jump.
- redirect_pc_i  in  ADDR_W  redirect target byte address.
- imem_addr_o  out  ADDR_W  instruction memory byte address; always equals the current PC.
- imem_instr_i  in  32  combinational read data for imem_addr_o.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  ADDR_W  PC of the IF/ID instruction.
- ifid_pc4_o  out  ADDR_W  ifid_pc_o+4.
- ifid_instr_o  out  32  instruction word; 0 (NOP) when invalid.
- fetch_cnt_o  out  32  count of valid IF/ID captures.
- running_o  out  1  state==RUN.
- fault_o  out  1  state==FAULT.

Behaviour:
- Reset (rst_i=1 at an edge, any state, overrides every other input):
  - pc=RESET_PC, state=IDLE.
  - ifid_valid/pc/pc4/instr=0, fetch_cnt=0.
  - running_o=0, fault_o=0.
- States: IDLE, RUN, FAULT.
- IDLE:
  - pc held; IF/ID held invalid; stall/flush/redirect ignored.
  - start_i=1 at an edge -> RUN. No capture on that edge.
- RUN, evaluated each edge in priority order:
  1. Redirect: redirect_i=1 and redirect_pc_i[1:0]==0:
     - pc<=redirect_pc_i.
     - IF/ID<=bubble (valid=0, instr=0, pc/pc4=0).
     - Applies even when stall_i=1.
  2. Misaligned redirect: redirect_i=1 and redirect_pc_i[1:0]!=0:
     - state<=FAULT, pc held, IF/ID<=bubble.
  3. Stall: stall_i=1. pc held. IF/ID held, unless flush_i=1, in which case IF/ID<=bubble.
  4. Out of range: pc >= IMEM_DEPTH*4 -> state<=FAULT, IF/ID<=bubble, pc held.
  5. Normal:
     - pc<=pc+4 (modulo 2^ADDR_W).
     - If flush_i=1: IF/ID<=bubble.
     - Else: IF/ID<={valid=1, pc, pc+4, imem_instr_i} and fetch_cnt<=fetch_cnt+1 (wraps 2^32->0).
- Latency: instruction at PC p appears on ifid_* one edge after imem_addr_o=p, provided there is no stall/flush/redirect.
- start_i is ignored outside IDLE; deasserting it in RUN does not stop fetch.
- FAULT:
  - All state frozen (pc, IF/ID bubble, fetch_cnt); fault_o=1.
  - Exit only via rst_i.
- No combinational path from any input to any output except imem_addr_o = pc register.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {IDLE, RUN, FAULT}.
  - INSTR_NOP=32'h0000_0000.
  - PC_STEP=4.
  - MIPS opcode constants for bench decode.
- One sub-module, if_id_reg: holds valid/pc/pc4/instr with hold (stall), bubble (flush) and load controls.
- PC, FSM and counter stay in fetch_unit.

Test Plan:
- Start sequence: reset 1 cycle, start_i=1 with memory word0=32'h2008_0005 -> first edge RUN with ifid_valid=0; next edge ifid_pc=0, ifid_instr=32'h2008_0005, fetch_cnt=1; imem_addr_o steps 0,4,8,...
- Stall: stall_i=1 for 3 cycles at pc=12 -> imem_addr_o stays 12 and ifid_* unchanged for 3 edges; release -> ifid_pc=12 next edge.
- Redirect+stall same edge: redirect_pc_i=32'h40 -> pc=0x40, ifid_valid=0; following edge ifid_pc=0x40, fetch_cnt unchanged on the bubble edge.
- Faults:
  - IMEM_DEPTH=4, run straight-line -> after capturing pc=12, pc=16 triggers FAULT; fault_o=1, fetch_cnt=4, outputs frozen for 10+ cycles.
  - Separately, redirect_pc_i=32'h22 -> immediate FAULT, pc unchanged.
- Reset mid-run and flush:
  - rst_i during RUN at pc=0x20 with stall_i=1 -> pc=0, state IDLE, all IF/ID zero, fetch_cnt=0; start_i held high -> RUN next edge.
  - flush_i alone -> pc advances by 4, ifid_valid=0.
